// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard
// Carries the decoder's ID-stage control word down the ID/EX, EX/MEM and MEM/WB
// pipeline registers and resolves hazards for a 5-stage RV32I pipeline:
// load-use stall, redirect flush, bubble insertion and EX operand forwarding.
//
// Build option: FORWARD_EN
//   defined   : EX operand forwarding from EX/MEM and MEM/WB; only load-use stalls.
//   undefined : forwarding selects tied to 00; ID stalls while any producer of a
//               source it reads is still in EX or MEM.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_*                            decoder control word, sources/destination, valid
//   ex_redirect                     EX resolved a taken branch/jal/jalr
//   ex_* / mem_* / wb_*             registered control word per stage
//   stall_if                        hold PC and IF/ID
//   flush_id                        zero IF/ID on the next edge
//   fwd_a_sel, fwd_b_sel            00 regfile, 01 EX/MEM result, 10 MEM/WB write data
module pipe_ctrl_hazard #(
    parameter int RA_W    = 5,
    parameter int NPC_W   = 2,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [NPC_W-1:0]   id_npc_op,
    input  logic               id_alub_sel,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic [1:0]         id_wd_sel,
    input  logic               id_dram_we,
    input  logic               id_rf_we,
    input  logic               id_is_load,
    input  logic [RA_W-1:0]    id_rs1,
    input  logic [RA_W-1:0]    id_rs2,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic [RA_W-1:0]    id_rd,
    input  logic               ex_redirect,
    output logic               ex_valid,
    output logic [NPC_W-1:0]   ex_npc_op,
    output logic               ex_alub_sel,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [1:0]         ex_wd_sel,
    output logic               ex_dram_we,
    output logic               ex_rf_we,
    output logic               ex_is_load,
    output logic [RA_W-1:0]    ex_rs1,
    output logic [RA_W-1:0]    ex_rs2,
    output logic [RA_W-1:0]    ex_rd,
    output logic               mem_valid,
    output logic [NPC_W-1:0]   mem_npc_op,
    output logic               mem_alub_sel,
    output logic [ALUOP_W-1:0] mem_alu_op,
    output logic [1:0]         mem_wd_sel,
    output logic               mem_dram_we,
    output logic               mem_rf_we,
    output logic               mem_is_load,
    output logic [RA_W-1:0]    mem_rs1,
    output logic [RA_W-1:0]    mem_rs2,
    output logic [RA_W-1:0]    mem_rd,
    output logic               wb_valid,
    output logic [NPC_W-1:0]   wb_npc_op,
    output logic               wb_alub_sel,
    output logic [ALUOP_W-1:0] wb_alu_op,
    output logic [1:0]         wb_wd_sel,
    output logic               wb_dram_we,
    output logic               wb_rf_we,
    output logic               wb_is_load,
    output logic [RA_W-1:0]    wb_rs1,
    output logic [RA_W-1:0]    wb_rs2,
    output logic [RA_W-1:0]    wb_rd,
    output logic               stall_if,
    output logic               flush_id,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel
);

    typedef struct packed {
        logic               valid;
        logic [NPC_W-1:0]   npc_op;
        logic               alub_sel;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         wd_sel;
        logic               dram_we;
        logic               rf_we;
        logic               is_load;
        logic [RA_W-1:0]    rs1;
        logic [RA_W-1:0]    rs2;
        logic [RA_W-1:0]    rd;
    } stage_t;

    stage_t id_gated;
    stage_t ex_d, ex_q;
    stage_t mem_d, mem_q;
    stage_t wb_d, wb_q;

    logic ex_dep;
    logic hazard;
    logic insert_bubble;

    // An invalid ID slot is captured as an all-zero bubble.
    always_comb begin
        id_gated = '0;
        if (id_valid) begin
            id_gated.valid    = 1'b1;
            id_gated.npc_op   = id_npc_op;
            id_gated.alub_sel = id_alub_sel;
            id_gated.alu_op   = id_alu_op;
            id_gated.wd_sel   = id_wd_sel;
            id_gated.dram_we  = id_dram_we;
            id_gated.rf_we    = id_rf_we;
            id_gated.is_load  = id_is_load;
            id_gated.rs1      = id_rs1;
            id_gated.rs2      = id_rs2;
            id_gated.rd       = id_rd;
        end
    end

    // ID reads the register that the EX instruction writes (x0 never counts).
    assign ex_dep = id_valid & (ex_q.rd != '0) &
                    ((id_rs1_used & (id_rs1 == ex_q.rd)) |
                     (id_rs2_used & (id_rs2 == ex_q.rd)));

`ifdef FORWARD_EN
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    assign hazard = ex_q.valid & ex_q.is_load & ex_dep;

    // A load in MEM has no result yet, so it cannot supply EX/MEM forwarding.
    assign mem_fwd_ok = mem_q.valid & mem_q.rf_we & (mem_q.rd != '0) & ~mem_q.is_load;
    assign wb_fwd_ok  = wb_q.valid & wb_q.rf_we & (wb_q.rd != '0);

    always_comb begin
        fwd_a_sel = 2'b00;
        if (mem_fwd_ok && (mem_q.rd == ex_q.rs1)) begin
            fwd_a_sel = 2'b01;
        end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs1)) begin
            fwd_a_sel = 2'b10;
        end
    end

    always_comb begin
        fwd_b_sel = 2'b00;
        if (mem_fwd_ok && (mem_q.rd == ex_q.rs2)) begin
            fwd_b_sel = 2'b01;
        end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs2)) begin
            fwd_b_sel = 2'b10;
        end
    end
`else
    logic mem_dep;

    // Without forwarding a result is visible only once it reaches the
    // write-first register file in WB, so producers in EX or MEM block ID.
    assign mem_dep = id_valid & (mem_q.rd != '0) &
                     ((id_rs1_used & (id_rs1 == mem_q.rd)) |
                      (id_rs2_used & (id_rs2 == mem_q.rd)));

    assign hazard = (ex_q.valid & ex_q.rf_we & ex_dep) |
                    (mem_q.valid & mem_q.rf_we & mem_dep);

    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    // Redirect wins over a stall; rst_n gating drops both strobes as soon as
    // reset asserts, independent of the (possibly still active) redirect input.
    assign stall_if      = rst_n & hazard & ~ex_redirect;
    assign flush_id      = rst_n & ex_redirect;
    assign insert_bubble = hazard | ex_redirect;

    always_comb begin
        ex_d  = insert_bubble ? '0 : id_gated;
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_npc_op    = ex_q.npc_op;
    assign ex_alub_sel  = ex_q.alub_sel;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_wd_sel    = ex_q.wd_sel;
    assign ex_dram_we   = ex_q.dram_we;
    assign ex_rf_we     = ex_q.rf_we;
    assign ex_is_load   = ex_q.is_load;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;

    assign mem_valid    = mem_q.valid;
    assign mem_npc_op   = mem_q.npc_op;
    assign mem_alub_sel = mem_q.alub_sel;
    assign mem_alu_op   = mem_q.alu_op;
    assign mem_wd_sel   = mem_q.wd_sel;
    assign mem_dram_we  = mem_q.dram_we;
    assign mem_rf_we    = mem_q.rf_we;
    assign mem_is_load  = mem_q.is_load;
    assign mem_rs1      = mem_q.rs1;
    assign mem_rs2      = mem_q.rs2;
    assign mem_rd       = mem_q.rd;

    assign wb_valid     = wb_q.valid;
    assign wb_npc_op    = wb_q.npc_op;
    assign wb_alub_sel  = wb_q.alub_sel;
    assign wb_alu_op    = wb_q.alu_op;
    assign wb_wd_sel    = wb_q.wd_sel;
    assign wb_dram_we   = wb_q.dram_we;
    assign wb_rf_we     = wb_q.rf_we;
    assign wb_is_load   = wb_q.is_load;
    assign wb_rs1       = wb_q.rs1;
    assign wb_rs2       = wb_q.rs2;
    assign wb_rd        = wb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Testbench for pipe_ctrl_hazard: directed RV32I hazard scenarios followed by a
// random instruction stream, all checked against an in-bench pipeline model.
module tb_pipe_ctrl_hazard;

    typedef struct packed {
        logic       valid;
        logic [1:0] npc_op;
        logic       alub_sel;
        logic [3:0] alu_op;
        logic [1:0] wd_sel;
        logic       dram_we;
        logic       rf_we;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } stage_t;

    typedef struct packed {
        stage_t f;
        logic   rs1_used;
        logic   rs2_used;
    } instr_t;

`ifdef FORWARD_EN
    localparam int EXP_DEP_STALL = 0;
    localparam int EXP_LU_STALL  = 1;
    localparam logic [1:0] EXP_SUB_FWD = 2'b01;
    localparam logic [1:0] EXP_LU_FWD  = 2'b10;
`else
    localparam int EXP_DEP_STALL = 2;
    localparam int EXP_LU_STALL  = 2;
    localparam logic [1:0] EXP_SUB_FWD = 2'b00;
    localparam logic [1:0] EXP_LU_FWD  = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_alub_sel, id_dram_we, id_rf_we, id_is_load;
    logic [1:0] id_npc_op, id_wd_sel;
    logic [3:0] id_alu_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic id_rs1_used, id_rs2_used, ex_redirect;

    logic ex_valid, ex_alub_sel, ex_dram_we, ex_rf_we, ex_is_load;
    logic [1:0] ex_npc_op, ex_wd_sel;
    logic [3:0] ex_alu_op;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic mem_valid, mem_alub_sel, mem_dram_we, mem_rf_we, mem_is_load;
    logic [1:0] mem_npc_op, mem_wd_sel;
    logic [3:0] mem_alu_op;
    logic [4:0] mem_rs1, mem_rs2, mem_rd;
    logic wb_valid, wb_alub_sel, wb_dram_we, wb_rf_we, wb_is_load;
    logic [1:0] wb_npc_op, wb_wd_sel;
    logic [3:0] wb_alu_op;
    logic [4:0] wb_rs1, wb_rs2, wb_rd;
    logic stall_if, flush_id;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    always #5 clk = ~clk;

    pipe_ctrl_hazard dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_npc_op(id_npc_op), .id_alub_sel(id_alub_sel),
        .id_alu_op(id_alu_op), .id_wd_sel(id_wd_sel), .id_dram_we(id_dram_we),
        .id_rf_we(id_rf_we), .id_is_load(id_is_load), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .ex_redirect(ex_redirect),
        .ex_valid(ex_valid), .ex_npc_op(ex_npc_op), .ex_alub_sel(ex_alub_sel),
        .ex_alu_op(ex_alu_op), .ex_wd_sel(ex_wd_sel), .ex_dram_we(ex_dram_we),
        .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_npc_op(mem_npc_op), .mem_alub_sel(mem_alub_sel),
        .mem_alu_op(mem_alu_op), .mem_wd_sel(mem_wd_sel), .mem_dram_we(mem_dram_we),
        .mem_rf_we(mem_rf_we), .mem_is_load(mem_is_load), .mem_rs1(mem_rs1),
        .mem_rs2(mem_rs2), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_npc_op(wb_npc_op), .wb_alub_sel(wb_alub_sel),
        .wb_alu_op(wb_alu_op), .wb_wd_sel(wb_wd_sel), .wb_dram_we(wb_dram_we),
        .wb_rf_we(wb_rf_we), .wb_is_load(wb_is_load), .wb_rs1(wb_rs1), .wb_rs2(wb_rs2),
        .wb_rd(wb_rd),
        .stall_if(stall_if), .flush_id(flush_id),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    stage_t obs_ex, obs_mem, obs_wb;
    assign obs_ex  = {ex_valid, ex_npc_op, ex_alub_sel, ex_alu_op, ex_wd_sel,
                      ex_dram_we, ex_rf_we, ex_is_load, ex_rs1, ex_rs2, ex_rd};
    assign obs_mem = {mem_valid, mem_npc_op, mem_alub_sel, mem_alu_op, mem_wd_sel,
                      mem_dram_we, mem_rf_we, mem_is_load, mem_rs1, mem_rs2, mem_rd};
    assign obs_wb  = {wb_valid, wb_npc_op, wb_alub_sel, wb_alu_op, wb_wd_sel,
                      wb_dram_we, wb_rf_we, wb_is_load, wb_rs1, wb_rs2, wb_rd};

    // Model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    stage_t pipe [3];
    int n_cmp = 0;
    int n_fail = 0;
    int obs_stalls = 0;
    int obs_flushes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input instr_t i, input logic redir);
        id_valid    = i.f.valid;
        id_npc_op   = i.f.npc_op;
        id_alub_sel = i.f.alub_sel;
        id_alu_op   = i.f.alu_op;
        id_wd_sel   = i.f.wd_sel;
        id_dram_we  = i.f.dram_we;
        id_rf_we    = i.f.rf_we;
        id_is_load  = i.f.is_load;
        id_rs1      = i.f.rs1;
        id_rs2      = i.f.rs2;
        id_rd       = i.f.rd;
        id_rs1_used = i.rs1_used;
        id_rs2_used = i.rs2_used;
        ex_redirect = redir;
    endtask

    function automatic logic needs(input instr_t i, input logic [4:0] r);
        return i.f.valid && (r != 5'd0) &&
               ((i.rs1_used && i.f.rs1 == r) || (i.rs2_used && i.f.rs2 == r));
    endfunction

    // With forwarding only a load still in EX is too late; without it any
    // register producer in EX or MEM is not yet in the register file.
    function automatic logic exp_hazard(input instr_t i);
        logic h_fwd = pipe[0].valid && pipe[0].is_load && needs(i, pipe[0].rd);
        logic h_nofwd = 1'b0;
        for (int s = 0; s < 2; s++)
            if (pipe[s].valid && pipe[s].rf_we && needs(i, pipe[s].rd)) h_nofwd = 1'b1;
`ifdef FORWARD_EN
        return h_fwd;
`else
        return h_nofwd | (h_fwd & 1'b0);
`endif
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        logic [1:0] fw = 2'b00;
        if (src != 5'd0 && pipe[1].valid && pipe[1].rf_we && !pipe[1].is_load && pipe[1].rd == src)
            fw = 2'b01;
        else if (src != 5'd0 && pipe[2].valid && pipe[2].rf_we && pipe[2].rd == src)
            fw = 2'b10;
`ifndef FORWARD_EN
        fw = 2'b00;
`endif
        return fw;
    endfunction

    // One clock: present ID + redirect, compare at the falling edge, advance model.
    // st/fl are the model's view, used to emulate the IF/ID register.
    task automatic step(input instr_t i, input logic redir, output logic st, output logic fl,
                        output logic [1:0] fa, output logic [1:0] fb);
        logic hz;
        drive(i, redir);
        @(negedge clk);
        hz = exp_hazard(i);
        chk("stall_if", 32'(stall_if), 32'(hz && !redir));
        chk("flush_id", 32'(flush_id), 32'(redir));
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(exp_fwd(pipe[0].rs1)));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(exp_fwd(pipe[0].rs2)));
        chk("ex_stage", 32'(obs_ex), 32'(pipe[0]));
        chk("mem_stage", 32'(obs_mem), 32'(pipe[1]));
        chk("wb_stage", 32'(obs_wb), 32'(pipe[2]));
        if (stall_if === 1'b1) obs_stalls++;
        if (flush_id === 1'b1) obs_flushes++;
        fa = fwd_a_sel;
        fb = fwd_b_sel;
        st = hz && !redir;
        fl = redir;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (hz || redir || !i.f.valid) ? '0 : i.f;
        @(posedge clk);
        #1;
    endtask

    // Hold an instruction in ID until it leaves (or is flushed).
    task automatic issue(input instr_t i, input logic redir_first);
        logic st, fl;
        logic [1:0] fa, fb;
        logic r = redir_first;
        int n = 0;
        do begin
            step(i, r, st, fl, fa, fb);
            r = 1'b0;
            n++;
        end while (st && !fl && n < 6);
        chk("issue_bound", 32'(st && !fl), 32'd0);
    endtask

    function automatic instr_t mk(input logic [1:0] npc, input logic alub, input logic [3:0] op,
                                  input logic [1:0] wd, input logic dwe, input logic rwe,
                                  input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic u1, input logic u2);
        instr_t i;
        i.f = '{valid: 1'b1, npc_op: npc, alub_sel: alub, alu_op: op, wd_sel: wd,
                dram_we: dwe, rf_we: rwe, is_load: ld, rs1: rs1, rs2: rs2, rd: rd};
        i.rs1_used = u1;
        i.rs2_used = u2;
        return i;
    endfunction

    function automatic instr_t alu_rr(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b,
                                      input logic [3:0] op);
        return mk(2'b00, 1'b0, op, 2'b00, 1'b0, 1'b1, 1'b0, rd, a, b, 1'b1, 1'b1);
    endfunction

    function automatic instr_t alu_i(input logic [4:0] rd, input logic [4:0] a);
        return mk(2'b00, 1'b1, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0, rd, a, 5'd0, 1'b1, 1'b0);
    endfunction

    function automatic instr_t load(input logic [4:0] rd, input logic [4:0] a);
        return mk(2'b00, 1'b1, 4'd0, 2'b01, 1'b0, 1'b1, 1'b1, rd, a, 5'd0, 1'b1, 1'b0);
    endfunction

    function automatic instr_t rand_instr();
        logic [4:0] rd = 5'($urandom_range(0, 3));
        logic [4:0] a  = 5'($urandom_range(0, 3));
        logic [4:0] b  = 5'($urandom_range(0, 3));
        instr_t i;
        case ($urandom_range(0, 7))
            0, 1: i = alu_rr(rd, a, b, 4'($urandom_range(0, 15)));
            2:    i = alu_i(rd, a);
            3:    i = load(rd, a);
            4:    i = mk(2'b00, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0, a, b, 1'b1, 1'b1);
            5:    i = mk(2'b11, 1'b0, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, a, b, 1'b1, 1'b1);
            6:    i = mk(2'b10, 1'b1, 4'd0, 2'b10, 1'b0, 1'b1, 1'b0, rd, 5'd0, 5'd0, 1'b0, 1'b0);
            default: begin
                // Invalid slot with junk fields: must be captured as a bubble.
                i = instr_t'($urandom);
                i.f.valid  = 1'b0;
                i.rs1_used = 1'b0;
                i.rs2_used = 1'b0;
            end
        endcase
        return i;
    endfunction

    task automatic drain(input int n);
        logic st, fl;
        logic [1:0] fa, fb;
        for (int k = 0; k < n; k++) step('0, 1'b0, st, fl, fa, fb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st, fl, redir;
        logic [1:0] fa, fb;
        instr_t cur;

        // Reset values
        rst_n = 1'b0;
        drive('0, 1'b0);
        for (int s = 0; s < 3; s++) pipe[s] = '0;
        #2;
        chk("rst_ex", 32'(obs_ex), 32'd0);
        chk("rst_mem", 32'(obs_mem), 32'd0);
        chk("rst_wb", 32'(obs_wb), 32'd0);
        chk("rst_stall", 32'(stall_if), 32'd0);
        chk("rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi x0,x0,1 ; add x3,x0,x0 : x0 never forwarded, never stalls
        obs_stalls = 0;
        issue(alu_i(5'd0, 5'd0), 1'b0);
        issue(alu_rr(5'd3, 5'd0, 5'd0, 4'd0), 1'b0);
        step('0, 1'b0, st, fl, fa, fb);
        chk("x0_fwd", 32'({fa, fb}), 32'd0);
        chk("x0_stall", 32'(obs_stalls), 32'd0);
        drain(3);

        // addi x5,x0,7 ; sub x6,x5,x5
        obs_stalls = 0;
        issue(alu_i(5'd5, 5'd0), 1'b0);
        issue(alu_rr(5'd6, 5'd5, 5'd5, 4'd1), 1'b0);
        step('0, 1'b0, st, fl, fa, fb);
        chk("dep_fwd_a", 32'(fa), 32'(EXP_SUB_FWD));
        chk("dep_fwd_b", 32'(fb), 32'(EXP_SUB_FWD));
        chk("dep_stalls", 32'(obs_stalls), 32'(EXP_DEP_STALL));
        drain(3);

        // lw x5,0(x1) ; add x6,x5,x2
        issue(load(5'd5, 5'd1), 1'b0);
        obs_stalls = 0;
        issue(alu_rr(5'd6, 5'd5, 5'd2, 4'd0), 1'b0);
        step('0, 1'b0, st, fl, fa, fb);
        chk("lu_fwd_a", 32'(fa), 32'(EXP_LU_FWD));
        chk("lu_stalls", 32'(obs_stalls), 32'(EXP_LU_STALL));
        drain(3);

        // Redirect while ID holds a load-dependent instruction: flush wins
        issue(load(5'd5, 5'd1), 1'b0);
        obs_stalls = 0;
        obs_flushes = 0;
        issue(alu_rr(5'd6, 5'd5, 5'd2, 4'd0), 1'b1);
        chk("redir_stalls", 32'(obs_stalls), 32'd0);
        chk("redir_flushes", 32'(obs_flushes), 32'd1);
        drain(4);

        // Reset asserted in the middle of a stall
        issue(load(5'd5, 5'd1), 1'b0);
        drive(alu_rr(5'd6, 5'd5, 5'd2, 4'd0), 1'b0);
        #2;
        chk("pre_rst_stall", 32'(stall_if), 32'd1);
        ex_redirect = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'd0);
        chk("mid_rst_stall", 32'(stall_if), 32'd0);
        chk("mid_rst_flush", 32'(flush_id), 32'd0);
        chk("mid_rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        drive('0, 1'b0);
        for (int s = 0; s < 3; s++) pipe[s] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random instruction stream with IF/ID emulation
        cur = rand_instr();
        for (int k = 0; k < 600; k++) begin
            redir = pipe[0].valid && (pipe[0].npc_op != 2'b00) && ($urandom_range(0, 1) == 1);
            step(cur, redir, st, fl, fa, fb);
            if (fl) cur = '0;
            else if (!st) cur = rand_instr();
        end
        drain(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
